// File: rtl/cfg_sequencer.sv
// cfg_sequencer: loads a WIDTH-bit configuration image into the serial config
// chain (sr_enable/sr_data), waits a fixed settle time, optionally waits for the
// synchronized DLL stable flag, then reports done with locked or timeout_err.
// Optional feature macro: CFG_SEQ_RETRY_EN (reload the same image after a lock
// timeout, up to RETRIES extra attempts).

module cfg_sequencer #(
  parameter int unsigned WIDTH         = 86,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned RETRIES       = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [WIDTH-1:0]           cfg,
  input  logic                       wait_lock,
  input  logic                       stable,
  output logic                       sr_enable,
  output logic                       sr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       locked,
  output logic                       timeout_err,
  output logic [$clog2(WIDTH+1)-1:0] bit_idx
);

  localparam int unsigned IdxW   = $clog2(WIDTH + 1);
  localparam int unsigned PosW   = $clog2(WIDTH);
  localparam int unsigned CntMax = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StShift    = 3'd1;
  localparam logic [2:0] StSettle   = 3'd2;
  localparam logic [2:0] StWaitLock = 3'd3;
  localparam logic [2:0] StDone     = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] img_q, img_d;
  logic             wl_q, wl_d;
  logic [IdxW-1:0]  bit_idx_q, bit_idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sr_enable_q, sr_enable_d;
  logic             sr_data_q, sr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             stable_s1_q, stable_s2_q;
  logic [31:0]      idx_ext;
  logic [PosW-1:0]  nxt_pos;

`ifdef CFG_SEQ_RETRY_EN
  localparam int unsigned RtyW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
  logic [RtyW-1:0] retry_q, retry_d;
`else
  // RETRIES only matters when reloads are enabled.
  logic unused_retries;
  assign unused_retries = ^RETRIES;
`endif

  // Two-flop synchronizer for the asynchronous DLL stable flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_s1_q <= 1'b0;
      stable_s2_q <= 1'b0;
    end else begin
      stable_s1_q <= stable;
      stable_s2_q <= stable_s1_q;
    end
  end

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d     = state_q;
    img_d       = img_q;
    wl_d        = wl_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    sr_enable_d = sr_enable_q;
    sr_data_d   = sr_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
`ifdef CFG_SEQ_RETRY_EN
    retry_d     = retry_q;
`endif
    // Position of the bit presented after the current one (MSB first).
    idx_ext     = 32'(bit_idx_q);
    nxt_pos     = PosW'(WIDTH - 32'd2 - idx_ext);

    case (state_q)
      StIdle: begin
        if (start) begin
          img_d       = cfg;
          wl_d        = wait_lock;
          locked_d    = 1'b0;
          timeout_d   = 1'b0;
          busy_d      = 1'b1;
          bit_idx_d   = '0;
          sr_enable_d = 1'b1;
          sr_data_d   = cfg[WIDTH-1];
`ifdef CFG_SEQ_RETRY_EN
          retry_d     = '0;
`endif
          state_d     = StShift;
        end
      end

      StShift: begin
        if (bit_idx_q == IdxW'(WIDTH - 1)) begin
          sr_enable_d = 1'b0;
          sr_data_d   = 1'b0;
          bit_idx_d   = IdxW'(WIDTH);
          cnt_d       = '0;
          state_d     = StSettle;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
          sr_data_d = img_q[nxt_pos];
        end
      end

      StSettle: begin
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          if (wl_q) begin
            state_d = StWaitLock;
          end else begin
            locked_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = StDone;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWaitLock: begin
        // Lock is checked first so a rise in the final cycle still wins.
        if (stable_s2_q) begin
          locked_d = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == CntW'(LOCK_TIMEOUT - 1)) begin
          cnt_d = '0;
`ifdef CFG_SEQ_RETRY_EN
          if (retry_q < RtyW'(RETRIES)) begin
            retry_d     = retry_q + 1'b1;
            bit_idx_d   = '0;
            sr_enable_d = 1'b1;
            sr_data_d   = img_q[WIDTH-1];
            state_d     = StShift;
          end else begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = StDone;
          end
`else
          timeout_d = 1'b1;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StDone;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      img_q       <= '0;
      wl_q        <= 1'b0;
      bit_idx_q   <= '0;
      cnt_q       <= '0;
      sr_enable_q <= 1'b0;
      sr_data_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef CFG_SEQ_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      img_q       <= img_d;
      wl_q        <= wl_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      sr_enable_q <= sr_enable_d;
      sr_data_q   <= sr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
`ifdef CFG_SEQ_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign sr_enable   = sr_enable_q;
  assign sr_data     = sr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign locked      = locked_q;
  assign timeout_err = timeout_q;
  assign bit_idx     = bit_idx_q;

endmodule

// File: tb/tb_cfg_sequencer.sv
// Directed bench for cfg_sequencer. Cycle numbering: the cycle in which start
// is driven high is cycle 0; the shifted bits occupy cycles 1..86.
module tb_cfg_sequencer;

  localparam int W  = 86;
  localparam int S  = 16;
  localparam int LT = 1024;
`ifdef CFG_SEQ_RETRY_EN
  localparam int ExpBursts = 3;
  localparam int ExpToDone = 1 + W + S + LT + 2 * (W + S + LT);
`else
  localparam int ExpBursts = 1;
  localparam int ExpToDone = 1 + W + S + LT;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] cfg;
  logic         wait_lock;
  logic         stable;
  logic         sr_enable, sr_data, busy, done, locked, timeout_err;
  logic [6:0]   bit_idx;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] cfg_a = 86'h2A_5555_AAAA_0F0F_F0F0_1234;
  logic [W-1:0] cfg_b = 86'h15_AAAA_5555_F0F0_0F0F_EDCB;

  cfg_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S), .LOCK_TIMEOUT(LT), .RETRIES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg(cfg), .wait_lock(wait_lock),
    .stable(stable), .sr_enable(sr_enable), .sr_data(sr_data), .busy(busy), .done(done),
    .locked(locked), .timeout_err(timeout_err), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one load and observes it until a few cycles past done (or limit).
  task automatic run(input logic [W-1:0] c, input logic wl, input int stable_at,
                     input int restart_at, input int limit,
                     output int en_cnt, output int bursts, output logic burst_bad,
                     output logic [W-1:0] model, output int done_cnt, output int done_c,
                     output logic lk, output logic to, output int max_idx,
                     output int first_en_c, output logic lk0, output logic to0);
    logic prev_en;
    int   cur;
    en_cnt = 0; bursts = 0; burst_bad = 1'b0; model = '0; done_cnt = 0; done_c = -1;
    lk = 1'b0; to = 1'b0; max_idx = 0; first_en_c = -1; prev_en = 1'b0; cur = 0;
    lk0 = 1'bx; to0 = 1'bx;
    cfg = c; wait_lock = wl; start = 1'b1;
    tick();
    start = 1'b0;
    cfg = ~c;
    wait_lock = ~wl;
    for (int n = 0; n < limit; n++) begin
      if (n == 0) begin
        lk0 = locked;
        to0 = timeout_err;
      end
      if (sr_enable) begin
        en_cnt++;
        model = {model[W-2:0], sr_data};
        if (!prev_en) begin
          bursts++;
          cur = 0;
          if (first_en_c < 0) first_en_c = n + 1;
        end
        cur++;
      end else if (prev_en && cur != W) begin
        burst_bad = 1'b1;
      end
      prev_en = sr_enable;
      if (int'(bit_idx) > max_idx) max_idx = int'(bit_idx);
      if (done) begin
        done_cnt++;
        done_c = n + 1;
        lk = locked;
        to = timeout_err;
      end
      if (n == stable_at) stable = 1'b1;
      if (n == restart_at) begin
        start = 1'b1;
        cfg = cfg_b;
      end else begin
        start = 1'b0;
      end
      if (done_cnt > 0 && n + 1 >= done_c + 4) break;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; cfg = '0; wait_lock = 1'b0; stable = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({sr_enable, sr_data, busy, done, locked, timeout_err} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 000000",
               {sr_enable, sr_data, busy, done, locked, timeout_err});
    end
    n_cmp++;
    if (bit_idx !== 7'd0) begin
      n_err++;
      $display("FAIL reset_bit_idx: got %0d want 0", bit_idx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int en, bu, dc, dcc, mi, fe;
    logic bb, lk, to, lk0, to0;
    logic [W-1:0] m;
    run(cfg_a, 1'b0, -1, -1, 300, en, bu, bb, m, dc, dcc, lk, to, mi, fe, lk0, to0);
    n_cmp++;
    if (en !== W || bu !== 1 || bb !== 1'b0) begin
      n_err++;
      $display("FAIL basic_enable_cycles: got %0d in %0d bursts want %0d in 1", en, bu, W);
    end
    n_cmp++;
    if (fe !== 1) begin
      n_err++;
      $display("FAIL basic_first_enable: got cycle %0d want 1", fe);
    end
    n_cmp++;
    if (m !== cfg_a) begin
      n_err++;
      $display("FAIL basic_image: got %h want %h", m, cfg_a);
    end
    n_cmp++;
    if (dc !== 1 || dcc !== 1 + W + S) begin
      n_err++;
      $display("FAIL basic_done: got %0d pulses at cycle %0d want 1 at %0d", dc, dcc, 1 + W + S);
    end
    n_cmp++;
    if (lk !== 1'b1 || to !== 1'b0) begin
      n_err++;
      $display("FAIL basic_flags: got locked=%b timeout=%b want 1 0", lk, to);
    end
    n_cmp++;
    if (mi !== W) begin
      n_err++;
      $display("FAIL basic_bit_idx_max: got %0d want %0d", mi, W);
    end
  endtask

  task automatic test_lock();
    int en, bu, dc, dcc, mi, fe;
    logic bb, lk, to, lk0, to0;
    logic [W-1:0] m;
    // SETTLE entered in cycle W+1; stable rises 40 cycles later, in cycle W+41.
    run(cfg_b, 1'b1, W + 40, -1, 400, en, bu, bb, m, dc, dcc, lk, to, mi, fe, lk0, to0);
    n_cmp++;
    if (dc !== 1 || dcc <= W + 41 || dcc > W + 44) begin
      n_err++;
      $display("FAIL lock_done: got %0d pulses at cycle %0d want 1 in (%0d,%0d]",
               dc, dcc, W + 41, W + 44);
    end
    n_cmp++;
    if (lk !== 1'b1 || to !== 1'b0) begin
      n_err++;
      $display("FAIL lock_flags: got locked=%b timeout=%b want 1 0", lk, to);
    end
    n_cmp++;
    if (m !== cfg_b) begin
      n_err++;
      $display("FAIL lock_image: got %h want %h", m, cfg_b);
    end
    stable = 1'b0;
    tick(); tick(); tick(); tick();
    n_cmp++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL lock_sticky: got %b want 1", locked);
    end
  endtask

  task automatic test_timeout_retry();
    int en, bu, dc, dcc, mi, fe;
    logic bb, lk, to, lk0, to0;
    logic [W-1:0] m;
    run(cfg_a, 1'b1, -1, -1, 4000, en, bu, bb, m, dc, dcc, lk, to, mi, fe, lk0, to0);
    n_cmp++;
    if (lk0 !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_locked_cleared: got %b want 0", lk0);
    end
    n_cmp++;
    if (dc !== 1 || dcc !== ExpToDone) begin
      n_err++;
      $display("FAIL timeout_done: got %0d pulses at cycle %0d want 1 at %0d", dc, dcc, ExpToDone);
    end
    n_cmp++;
    if (to !== 1'b1 || lk !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flags: got timeout=%b locked=%b want 1 0", to, lk);
    end
    n_cmp++;
    if (bu !== ExpBursts || en !== ExpBursts * W || bb !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_bursts: got %0d bursts %0d bits want %0d bursts %0d bits",
               bu, en, ExpBursts, ExpBursts * W);
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got %b want 1", timeout_err);
    end
  endtask

  task automatic test_ignored_start();
    int en, bu, dc, dcc, mi, fe;
    logic bb, lk, to, lk0, to0;
    logic [W-1:0] m;
    run(cfg_a, 1'b0, -1, 20, 400, en, bu, bb, m, dc, dcc, lk, to, mi, fe, lk0, to0);
    n_cmp++;
    if (to0 !== 1'b0) begin
      n_err++;
      $display("FAIL restart_timeout_cleared: got %b want 0", to0);
    end
    n_cmp++;
    if (en !== W || m !== cfg_a) begin
      n_err++;
      $display("FAIL restart_image: got %0d bits %h want %0d bits %h", en, m, W, cfg_a);
    end
    n_cmp++;
    if (dc !== 1 || dcc !== 1 + W + S || lk !== 1'b1) begin
      n_err++;
      $display("FAIL restart_done: got %0d pulses at %0d locked=%b want 1 at %0d locked=1",
               dc, dcc, lk, 1 + W + S);
    end
  endtask

  task automatic test_reset_mid_shift();
    int en, bu, dc, dcc, mi, fe, seen;
    logic bb, lk, to, lk0, to0;
    logic [W-1:0] m;
    cfg = cfg_b; wait_lock = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 100 && bit_idx != 7'd40; n++) tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (sr_enable !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_drop: got enable=%b busy=%b want 0 0", sr_enable, busy);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done !== 1'b0) seen++;
    end
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done !== 1'b0 || sr_enable !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL midreset_no_done: got %0d active cycles want 0", seen);
    end
    run(cfg_a, 1'b0, -1, -1, 300, en, bu, bb, m, dc, dcc, lk, to, mi, fe, lk0, to0);
    n_cmp++;
    if (en !== W || m !== cfg_a || dc !== 1 || dcc !== 1 + W + S) begin
      n_err++;
      $display("FAIL midreset_reload: got %0d bits %h done %0d at %0d want %0d bits %h 1 at %0d",
               en, m, dc, dcc, W, cfg_a, 1 + W + S);
    end
  endtask

  task automatic test_back_to_back();
    int dn, cnt;
    logic gap_ok, rearm_ok;
    dn = -1; gap_ok = 1'b0; rearm_ok = 1'b0; cnt = 0;
    cfg = cfg_b; wait_lock = 1'b0; start = 1'b1;
    tick();
    for (int n = 0; n < 300; n++) begin
      if (done && dn < 0) dn = n;
      if (dn >= 0 && n == dn + 1) gap_ok = !sr_enable && !busy && !done;
      if (dn >= 0 && n == dn + 2) begin
        rearm_ok = sr_enable && busy && (sr_data == cfg_b[W-1]);
        break;
      end
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (dn !== W + S) begin
      n_err++;
      $display("FAIL b2b_first_done: got cycle %0d want %0d", dn + 1, W + S + 1);
    end
    n_cmp++;
    if (gap_ok !== 1'b1 || rearm_ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_rearm: got gap=%b rearm=%b want 1 1", gap_ok, rearm_ok);
    end
    for (int n = 0; n < 300; n++) begin
      if (done) cnt++;
      tick();
    end
    n_cmp++;
    if (cnt !== 1) begin
      n_err++;
      $display("FAIL b2b_second_done: got %0d pulses want 1", cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lock();
    test_timeout_retry();
    test_ignored_start();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
